bus_cycle_ctrl: RTL and testbench
=================================

Name: bus_cycle_ctrl

Overview:
- Bus cycle controller sitting between the i8088 core bus outputs (s2_s0_out, lock_n) and the system bus.
- Decodes CPU status into 8288-style ALE and command strobes.
- Inserts programmable wait states and drives the CPU READY input.
- Arbitrates the bus between the CPU and one DMA requester (HRQ/HLDA), honouring LOCK_n and never splitting a CPU bus cycle.

Parameters:
- MEM_WS, 1: wait states for memory and code cycles when turbo_mode=0.
- IO_WS, 1: wait states for I/O and INTA cycles, applied in both modes.
- WS_W, 4: width of the wait counter. MEM_WS and IO_WS must each be < 2**WS_W.

Ports:
- CLK  in  1  bus clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- S2_S0  in  3  CPU status: 000 INTA, 001 IOR, 010 IOW, 011 HALT, 100 CODE, 101 MEMR, 110 MEMW, 111 passive.
- LOCK_n  in  1  CPU lock; low blocks the DMA grant.
- turbo_mode  in  1  1 = zero memory waits; sampled in T1.
- IO_CH_RDY  in  1  device ready; 0 extends TW.
- DMA_HRQ  in  1  DMA hold request.
- DMA_HLDA  out  1  DMA hold acknowledge.
- AEN  out  1  address enable to DMA; equals DMA_HLDA.
- ALE  out  1  address latch enable, one CLK wide in T1.
- MEMR_n, MEMW_n, IOR_n, IOW_n, INTA_n  out  1 each  command strobes, active low.
- CPU_READY  out  1  to i8088 READY.

Behaviour:
- Reset: state=IDLE, pending=0, wait counter=0, ALE=0, all strobes=1, DMA_HLDA=AEN=0, CPU_READY=1. RESET asserted mid-cycle or mid-hold aborts to these values on the next edge.
- Status is registered as prev_s.
- Cycle start: S2_S0!=111 while prev_s==111 is a start event. This edge detect means a held status never restarts a cycle.
- States: IDLE, T1, T2, T3, TW, T4, HOLD.
- IDLE:
  - Start event or pending=1 -> T1; latch the cycle type and clear pending.
  - Otherwise, DMA_HRQ=1 && LOCK_n=1 && S2_S0==111 -> HOLD.
  - Simultaneous start event and DMA_HRQ: the CPU wins.
- T1:
  - ALE=1.
  - Wait counter loads: MEM_WS for CODE/MEMR/MEMW (0 if turbo_mode=1); IO_WS for IOR/IOW/INTA.
  - HALT type -> IDLE directly, with no strobe. All other types -> T2.
- T2: read strobes (MEMR_n for CODE/MEMR, IOR_n, INTA_n) assert low. CPU_READY=0. -> T3.
- T3/TW:
  - Write strobes (MEMW_n, IOW_n) assert low from T3. Read strobes stay low.
  - Exit when counter==0 && IO_CH_RDY==1: CPU_READY=1 combinationally in that cycle, -> T4.
  - Otherwise CPU_READY=0, -> TW, and the counter decrements if nonzero (saturates at 0).
  - IO_CH_RDY low holds the cycle in TW indefinitely.
- T4: all strobes high, CPU_READY=1, -> IDLE. Minimum cycle length is 4 CLKs (T1-T4) with zero waits.
- HOLD:
  - DMA_HLDA=AEN=1, registered, asserted the cycle after entry. CPU_READY=0. No strobes from this block.
  - A start event during HOLD sets pending=1; only one request is stored.
  - DMA_HRQ=0 -> IDLE; HLDA and AEN drop on the following edge.
  - If pending=1 on the return to IDLE, T1 follows on the next cycle.
- LOCK_n low: no HOLD entry. A DMA_HRQ held across locked cycles is granted at the first IDLE with LOCK_n=1.
- Outputs are registered state decodes, except CPU_READY in T3/TW.

Decomposition:
- Shared package bus_ctrl_pkg:
  - Status-code constants (ST_INTA … ST_PASSIVE).
  - bus_state_t enum.
  - cycle_class_t (MEM, IO, INTA, HALT).
  - A function mapping status to cycle_class_t.
- One sub-module, bus_wait_counter: load value, load strobe, decrement enable; outputs zero flag. Down-counter of WS_W bits, saturating at 0.

Test Plan:
- MEMR, turbo_mode=0, MEM_WS=1, IO_CH_RDY=1:
  - ALE at T1.
  - MEMR_n low T2-TW.
  - CPU_READY low T2, T3; high in TW.
  - Cycle is 5 CLKs; MEMW_n stays 1.
- Same MEMR with turbo_mode=1: 4 CLKs, no TW; CPU_READY=1 in T3.
- IOW with IO_WS=1, IO_CH_RDY low for 3 CLKs after T3: IOW_n low from T3; stays in TW until IO_CH_RDY=1; total 8 CLKs; IOR_n stays 1.
- DMA_HRQ=1 in IDLE with LOCK_n=1: HLDA=AEN=1 after 2 edges. Start an MEMR during HOLD, then drop HRQ: HLDA=0, then T1/ALE fires exactly once from pending.
- LOCK_n=0 across two back-to-back MEMW cycles with DMA_HRQ=1: HLDA stays 0 until LOCK_n=1 in IDLE.
- HALT (011): single ALE, no strobes, return to IDLE. Assert RESET during TW of an IOR: next cycle all strobes 1, CPU_READY=1, HLDA=0, state IDLE.

Source files
------------

// File: rtl/bus_cycle_ctrl_pkg.sv
// Shared types for the i8088 bus cycle controller: status codes, FSM states
// and the status-to-cycle-class mapping used by the wait-state logic.
package bus_ctrl_pkg;

  localparam logic [2:0] ST_INTA    = 3'b000;
  localparam logic [2:0] ST_IOR     = 3'b001;
  localparam logic [2:0] ST_IOW     = 3'b010;
  localparam logic [2:0] ST_HALT    = 3'b011;
  localparam logic [2:0] ST_CODE    = 3'b100;
  localparam logic [2:0] ST_MEMR    = 3'b101;
  localparam logic [2:0] ST_MEMW    = 3'b110;
  localparam logic [2:0] ST_PASSIVE = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_T3,
    S_TW,
    S_T4,
    S_HOLD
  } bus_state_t;

  typedef enum logic [1:0] {
    CC_MEM,
    CC_IO,
    CC_INTA,
    CC_HALT
  } cycle_class_t;

  // Passive never gets latched as a cycle type; it folds into HALT (no strobes).
  function automatic cycle_class_t status_class(input logic [2:0] s);
    case (s)
      ST_INTA:                   return CC_INTA;
      ST_IOR, ST_IOW:            return CC_IO;
      ST_CODE, ST_MEMR, ST_MEMW: return CC_MEM;
      ST_HALT:                   return CC_HALT;
      default:                   return CC_HALT;
    endcase
  endfunction

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// CPU/system-bus side signals of the bus cycle controller; the controller
// uses the slave view, the CPU/DMA/device side uses the master view.
interface bus_cycle_ctrl_if;

  logic [2:0] S2_S0;
  logic       LOCK_n;
  logic       turbo_mode;
  logic       IO_CH_RDY;
  logic       DMA_HRQ;
  logic       DMA_HLDA;
  logic       AEN;
  logic       ALE;
  logic       MEMR_n;
  logic       MEMW_n;
  logic       IOR_n;
  logic       IOW_n;
  logic       INTA_n;
  logic       CPU_READY;

  modport master (
    output S2_S0, LOCK_n, turbo_mode, IO_CH_RDY, DMA_HRQ,
    input  DMA_HLDA, AEN, ALE, MEMR_n, MEMW_n, IOR_n, IOW_n, INTA_n, CPU_READY
  );

  modport slave (
    input  S2_S0, LOCK_n, turbo_mode, IO_CH_RDY, DMA_HRQ,
    output DMA_HLDA, AEN, ALE, MEMR_n, MEMW_n, IOR_n, IOW_n, INTA_n, CPU_READY
  );

endinterface

// File: rtl/bus_cycle_ctrl_wait_counter.sv
// Wait-state down-counter: loaded in T1, decremented while the cycle is
// stretched, sticking at zero once the programmed waits are used up.
module bus_wait_counter #(
  parameter int WS_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [WS_W-1:0] load_val,
  input  logic            dec,
  output logic            zero
);

  logic [WS_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bus_cycle_ctrl.sv
// i8088 bus cycle controller: 8288-style ALE/command decode, programmable
// wait states driving CPU READY, and CPU/DMA bus arbitration via HRQ/HLDA.
module bus_cycle_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int MEM_WS = 1,
  parameter int IO_WS  = 1,
  parameter int WS_W   = 4
) (
  input logic             CLK,
  input logic             RESET,
  bus_cycle_ctrl_if.slave bus
);

  bus_state_t      state;
  logic [2:0]      prev_s;
  logic [2:0]      cyc_s;
  logic [2:0]      pend_s;
  logic            pending;
  logic            ale_q;
  logic            memr_n_q;
  logic            memw_n_q;
  logic            ior_n_q;
  logic            iow_n_q;
  logic            inta_n_q;
  logic            ready_q;
  logic            hlda_q;
  logic            start;
  logic            in_data;
  logic            wait_zero;
  logic            cyc_done;
  logic [WS_W-1:0] ws_load;

  assign start    = (bus.S2_S0 != ST_PASSIVE) && (prev_s == ST_PASSIVE);
  assign in_data  = (state == S_T3) || (state == S_TW);
  assign cyc_done = wait_zero && bus.IO_CH_RDY;

  always_comb begin
    ws_load = '0;
    case (status_class(cyc_s))
      CC_MEM:         ws_load = bus.turbo_mode ? '0 : WS_W'(MEM_WS);
      CC_IO, CC_INTA: ws_load = WS_W'(IO_WS);
      default:        ws_load = '0;
    endcase
  end

  bus_wait_counter #(.WS_W(WS_W)) u_wait (
    .clk      (CLK),
    .rst      (RESET),
    .load     (state == S_T1),
    .load_val (ws_load),
    .dec      (in_data && !cyc_done),
    .zero     (wait_zero)
  );

  // Outputs are set on entry to the state they belong to, so they line up with it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      prev_s   <= ST_PASSIVE;
      cyc_s    <= ST_PASSIVE;
      pend_s   <= ST_PASSIVE;
      pending  <= 1'b0;
      ale_q    <= 1'b0;
      memr_n_q <= 1'b1;
      memw_n_q <= 1'b1;
      ior_n_q  <= 1'b1;
      iow_n_q  <= 1'b1;
      inta_n_q <= 1'b1;
      ready_q  <= 1'b1;
      hlda_q   <= 1'b0;
    end else begin
      prev_s <= bus.S2_S0;
      hlda_q <= (state == S_HOLD);
      ale_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start || pending) begin
            state   <= S_T1;
            ale_q   <= 1'b1;
            cyc_s   <= pending ? pend_s : bus.S2_S0;
            pending <= 1'b0;
          end else if (bus.DMA_HRQ && bus.LOCK_n && (bus.S2_S0 == ST_PASSIVE)) begin
            state   <= S_HOLD;
            ready_q <= 1'b0;
          end
        end
        S_T1: begin
          if (status_class(cyc_s) == CC_HALT) begin
            state <= S_IDLE;
          end else begin
            state    <= S_T2;
            ready_q  <= 1'b0;
            memr_n_q <= !((cyc_s == ST_CODE) || (cyc_s == ST_MEMR));
            ior_n_q  <= (cyc_s != ST_IOR);
            inta_n_q <= (cyc_s != ST_INTA);
          end
        end
        S_T2: begin
          state    <= S_T3;
          memw_n_q <= (cyc_s != ST_MEMW);
          iow_n_q  <= (cyc_s != ST_IOW);
        end
        S_T3, S_TW: begin
          if (cyc_done) begin
            state    <= S_T4;
            ready_q  <= 1'b1;
            memr_n_q <= 1'b1;
            memw_n_q <= 1'b1;
            ior_n_q  <= 1'b1;
            iow_n_q  <= 1'b1;
            inta_n_q <= 1'b1;
          end else begin
            state <= S_TW;
          end
        end
        S_T4: begin
          state <= S_IDLE;
        end
        S_HOLD: begin
          // The CPU may begin a cycle while the bus is held; remember only the first.
          if (start && !pending) begin
            pending <= 1'b1;
            pend_s  <= bus.S2_S0;
          end
          if (!bus.DMA_HRQ) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ALE       = ale_q;
  assign bus.MEMR_n    = memr_n_q;
  assign bus.MEMW_n    = memw_n_q;
  assign bus.IOR_n     = ior_n_q;
  assign bus.IOW_n     = iow_n_q;
  assign bus.INTA_n    = inta_n_q;
  assign bus.DMA_HLDA  = hlda_q;
  assign bus.AEN       = hlda_q;
  assign bus.CPU_READY = in_data ? cyc_done : ready_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed self-checking bench for bus_cycle_ctrl: each scenario drives one
// input set per clock and compares all outputs against hand-derived vectors.
module tb_bus_cycle_ctrl;
  import bus_ctrl_pkg::*;

  // Output vector order: {ALE, MEMR_n, MEMW_n, IOR_n, IOW_n, INTA_n, CPU_READY, DMA_HLDA, AEN}
  localparam logic [8:0] V_IDLE = 9'b0_1_1_1_1_1_1_0_0;
  localparam logic [8:0] V_T1   = 9'b1_1_1_1_1_1_1_0_0;
  localparam logic [8:0] V_MR0  = 9'b0_0_1_1_1_1_0_0_0;
  localparam logic [8:0] V_MR1  = 9'b0_0_1_1_1_1_1_0_0;
  localparam logic [8:0] V_WT2  = 9'b0_1_1_1_1_1_0_0_0;
  localparam logic [8:0] V_MW0  = 9'b0_1_0_1_1_1_0_0_0;
  localparam logic [8:0] V_MW1  = 9'b0_1_0_1_1_1_1_0_0;
  localparam logic [8:0] V_IW0  = 9'b0_1_1_1_0_1_0_0_0;
  localparam logic [8:0] V_IW1  = 9'b0_1_1_1_0_1_1_0_0;
  localparam logic [8:0] V_IR0  = 9'b0_1_1_0_1_1_0_0_0;
  localparam logic [8:0] V_HLD0 = 9'b0_1_1_1_1_1_0_0_0;
  localparam logic [8:0] V_HLD1 = 9'b0_1_1_1_1_1_0_1_1;
  localparam logic [8:0] V_HREL = 9'b0_1_1_1_1_1_1_1_1;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   fails  = 0;

  always #5 CLK = ~CLK;

  bus_cycle_ctrl_if bus ();

  bus_cycle_ctrl #(.MEM_WS(1), .IO_WS(1), .WS_W(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  function automatic logic [8:0] outs();
    return {bus.ALE, bus.MEMR_n, bus.MEMW_n, bus.IOR_n, bus.IOW_n, bus.INTA_n,
            bus.CPU_READY, bus.DMA_HLDA, bus.AEN};
  endfunction

  // One clock: inputs change just after the edge, outputs are read 1ns later.
  task automatic drive(input logic [2:0] s, input logic hrq, input logic lock,
                       input logic rdy, input logic turbo, input logic rst);
    @(posedge CLK);
    #1;
    bus.S2_S0      = s;
    bus.DMA_HRQ    = hrq;
    bus.LOCK_n     = lock;
    bus.IO_CH_RDY  = rdy;
    bus.turbo_mode = turbo;
    RESET          = rst;
    #1;
  endtask

  task automatic test_reset();
    drive(ST_PASSIVE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(ST_PASSIVE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (outs() !== V_IDLE) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %b, expected %b", outs(), V_IDLE);
    end
    checks++;
    if (dut.state !== S_IDLE) begin
      fails++;
      $display("[TB] FAIL reset_state: got %0d, expected %0d", dut.state, S_IDLE);
    end
  endtask

  task automatic test_memr();
    logic [2:0] st [7] = '{ST_MEMR, ST_MEMR, ST_MEMR, ST_PASSIVE, ST_PASSIVE, ST_PASSIVE, ST_PASSIVE};
    logic [8:0] ex [7] = '{V_IDLE, V_T1, V_MR0, V_MR0, V_MR1, V_IDLE, V_IDLE};
    for (int i = 0; i < 7; i++) begin
      drive(st[i], 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (outs() !== ex[i]) begin
        fails++;
        $display("[TB] FAIL memr cycle %0d: got %b, expected %b", i, outs(), ex[i]);
      end
    end
  endtask

  task automatic test_memr_turbo();
    logic [2:0] st [6] = '{ST_MEMR, ST_MEMR, ST_MEMR, ST_PASSIVE, ST_PASSIVE, ST_PASSIVE};
    logic [8:0] ex [6] = '{V_IDLE, V_T1, V_MR0, V_MR1, V_IDLE, V_IDLE};
    for (int i = 0; i < 6; i++) begin
      drive(st[i], 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (outs() !== ex[i]) begin
        fails++;
        $display("[TB] FAIL memr_turbo cycle %0d: got %b, expected %b", i, outs(), ex[i]);
      end
    end
  endtask

  task automatic test_iow_wait();
    logic [2:0] st [10] = '{ST_IOW, ST_IOW, ST_IOW, ST_PASSIVE, ST_PASSIVE,
                            ST_PASSIVE, ST_PASSIVE, ST_PASSIVE, ST_PASSIVE, ST_PASSIVE};
    logic [0:9] rdy     = 10'b1111000111;
    logic [8:0] ex [10] = '{V_IDLE, V_T1, V_WT2, V_IW0, V_IW0, V_IW0, V_IW0, V_IW1, V_IDLE, V_IDLE};
    for (int i = 0; i < 10; i++) begin
      drive(st[i], 1'b0, 1'b1, rdy[i], 1'b0, 1'b0);
      checks++;
      if (outs() !== ex[i]) begin
        fails++;
        $display("[TB] FAIL iow_wait cycle %0d: got %b, expected %b", i, outs(), ex[i]);
      end
    end
  endtask

  task automatic test_halt();
    logic [2:0] st [5] = '{ST_HALT, ST_HALT, ST_HALT, ST_HALT, ST_PASSIVE};
    logic [8:0] ex [5] = '{V_IDLE, V_T1, V_IDLE, V_IDLE, V_IDLE};
    for (int i = 0; i < 5; i++) begin
      drive(st[i], 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (outs() !== ex[i]) begin
        fails++;
        $display("[TB] FAIL halt cycle %0d: got %b, expected %b", i, outs(), ex[i]);
      end
    end
  endtask

  task automatic test_dma_pending();
    logic [2:0] st [13] = '{ST_PASSIVE, ST_PASSIVE, ST_MEMR, ST_MEMR, ST_MEMR, ST_MEMR, ST_MEMR,
                            ST_PASSIVE, ST_PASSIVE, ST_PASSIVE, ST_PASSIVE, ST_PASSIVE, ST_PASSIVE};
    logic [0:12] hrq    = 13'b1111000000000;
    logic [8:0] ex [13] = '{V_IDLE, V_HLD0, V_HLD1, V_HLD1, V_HLD1, V_HREL, V_T1,
                            V_MR0, V_MR0, V_MR1, V_IDLE, V_IDLE, V_IDLE};
    for (int i = 0; i < 13; i++) begin
      drive(st[i], hrq[i], 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (outs() !== ex[i]) begin
        fails++;
        $display("[TB] FAIL dma_pending cycle %0d: got %b, expected %b", i, outs(), ex[i]);
      end
    end
  endtask

  task automatic test_lock();
    logic [2:0] st [19] = '{ST_MEMW, ST_MEMW, ST_MEMW, ST_PASSIVE, ST_PASSIVE, ST_PASSIVE, ST_PASSIVE,
                            ST_MEMW, ST_MEMW, ST_MEMW, ST_PASSIVE, ST_PASSIVE, ST_PASSIVE,
                            ST_PASSIVE, ST_PASSIVE, ST_PASSIVE, ST_PASSIVE, ST_PASSIVE, ST_PASSIVE};
    logic [0:18] lock   = 19'b0000000000000111111;
    logic [0:18] hrq    = 19'b1111111111111111000;
    logic [8:0] ex [19] = '{V_IDLE, V_T1, V_WT2, V_MW0, V_MW1, V_IDLE, V_IDLE,
                            V_IDLE, V_T1, V_WT2, V_MW0, V_MW1, V_IDLE,
                            V_IDLE, V_HLD0, V_HLD1, V_HLD1, V_HREL, V_IDLE};
    for (int i = 0; i < 19; i++) begin
      drive(st[i], hrq[i], lock[i], 1'b1, 1'b0, 1'b0);
      checks++;
      if (outs() !== ex[i]) begin
        fails++;
        $display("[TB] FAIL lock cycle %0d: got %b, expected %b", i, outs(), ex[i]);
      end
    end
  endtask

  task automatic test_reset_mid_cycle();
    logic [2:0] st [7] = '{ST_IOR, ST_IOR, ST_IOR, ST_PASSIVE, ST_PASSIVE, ST_PASSIVE, ST_PASSIVE};
    logic [0:6] rdy    = 7'b1110011;
    logic [0:6] rst    = 7'b0000100;
    logic [8:0] ex [7] = '{V_IDLE, V_T1, V_IR0, V_IR0, V_IR0, V_IDLE, V_IDLE};
    for (int i = 0; i < 7; i++) begin
      drive(st[i], 1'b0, 1'b1, rdy[i], 1'b0, rst[i]);
      checks++;
      if (outs() !== ex[i]) begin
        fails++;
        $display("[TB] FAIL reset_mid cycle %0d: got %b, expected %b", i, outs(), ex[i]);
      end
      if (i == 5) begin
        checks++;
        if (dut.state !== S_IDLE) begin
          fails++;
          $display("[TB] FAIL reset_mid_state: got %0d, expected %0d", dut.state, S_IDLE);
        end
      end
    end
  endtask

  initial begin
    RESET          = 1'b1;
    bus.S2_S0      = ST_PASSIVE;
    bus.LOCK_n     = 1'b1;
    bus.turbo_mode = 1'b0;
    bus.IO_CH_RDY  = 1'b1;
    bus.DMA_HRQ    = 1'b0;
    test_reset();
    test_memr();
    test_memr_turbo();
    test_iow_wait();
    test_halt();
    test_dma_pending();
    test_lock();
    test_reset_mid_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
